// File: rtl/win_readout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : win_readout_ctrl
//  Description : Reader side of the capture window. Once the window counter
//                reports the capture complete, it walks the circular sample
//                SRAM from the oldest to the newest sample. It hands each word
//                to the MCU with a request/valid handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module win_readout_ctrl #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WRITE_READY,
    input  logic [ADDR_W-1:0] STOP_ADDR,
    input  logic [ADDR_W-1:0] READ_LEN,
    input  logic              START_READ,
    input  logic              ABORT,
    input  logic              RD_REQ,
    output logic              RD_READY,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_VALID,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_OE,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic              BUSY,
    output logic              READ_DONE,
    output logic [ADDR_W-1:0] WORDS_LEFT
);

    // Latency counter counts MEM_LAT-1 down to 0; capture happens on the 0 edge.
    localparam int              c_lat_w     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_lat_w-1:0] c_lat_load = c_lat_w'(MEM_LAT - 1);
    // READ_LEN of 0 means the whole memory, which needs one extra counter bit.
    localparam logic [ADDR_W:0] c_full_depth = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W:0]     r_left;
    logic [c_lat_w-1:0]  r_lat;
    logic                r_rd_ready;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_oe;
    logic                r_busy;
    logic                r_read_done;
    logic [ADDR_W-1:0]   r_words_left;

    logic                w_start_ok;
    logic                w_abort;
    logic [ADDR_W-1:0]   w_start_addr;
    logic [ADDR_W:0]     w_start_len;
    logic [ADDR_W:0]     w_left_dec;

    // Start window: the oldest requested sample sits READ_LEN-1 words behind STOP_ADDR.
    assign w_start_ok   = START_READ & WRITE_READY;
    assign w_start_addr = STOP_ADDR - READ_LEN + ADDR_W'(1);
    assign w_start_len  = (READ_LEN == '0) ? c_full_depth : {1'b0, READ_LEN};
    assign w_left_dec   = r_left - (ADDR_W + 1)'(1);
    // Losing WRITE_READY mid-readout means the capture was re-armed, so the data is stale.
    assign w_abort      = ABORT | (~WRITE_READY & ((r_state == S_READY) | (r_state == S_WAIT)));

    // Readout state machine with all handshake and memory outputs registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_cur_addr   <= '0;
            r_left       <= '0;
            r_lat        <= '0;
            r_rd_ready   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_oe     <= 1'b0;
            r_busy       <= 1'b0;
            r_read_done  <= 1'b0;
            r_words_left <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            if (w_abort) begin
                r_state      <= S_IDLE;
                r_mem_oe     <= 1'b0;
                r_rd_ready   <= 1'b0;
                r_read_done  <= 1'b0;
                r_busy       <= 1'b0;
                r_words_left <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_ok) begin
                            r_cur_addr   <= w_start_addr;
                            r_left       <= w_start_len;
                            r_words_left <= READ_LEN;
                            r_rd_ready   <= 1'b1;
                            r_busy       <= 1'b1;
                            r_read_done  <= 1'b0;
                            r_state      <= S_READY;
                        end
                    end
                    S_READY: begin
                        // RD_READY is held low during the RD_VALID cycle, so a request
                        // is accepted only once RD_READY is actually showing high.
                        if (r_rd_ready && RD_REQ) begin
                            r_mem_addr <= r_cur_addr;
                            r_mem_oe   <= 1'b1;
                            r_lat      <= c_lat_load;
                            r_rd_ready <= 1'b0;
                            r_state    <= S_WAIT;
                        end else begin
                            r_rd_ready <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (r_lat == '0) begin
                            r_rd_data  <= MEM_DATA;
                            r_rd_valid <= 1'b1;
                            r_mem_oe   <= 1'b0;
                            r_cur_addr <= r_cur_addr + ADDR_W'(1);
                            r_left     <= w_left_dec;
                            if (w_left_dec == '0) begin
                                r_state      <= S_DONE;
                                r_busy       <= 1'b0;
                                r_read_done  <= 1'b1;
                                r_words_left <= '0;
                            end else begin
                                r_state      <= S_READY;
                                r_words_left <= w_left_dec[ADDR_W-1:0];
                            end
                        end else begin
                            r_lat <= r_lat - c_lat_w'(1);
                        end
                    end
                    S_DONE: begin
                        if (w_start_ok) begin
                            r_cur_addr   <= w_start_addr;
                            r_left       <= w_start_len;
                            r_words_left <= READ_LEN;
                            r_rd_ready   <= 1'b1;
                            r_busy       <= 1'b1;
                            r_read_done  <= 1'b0;
                            r_state      <= S_READY;
                        end else if (!WRITE_READY) begin
                            r_read_done <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign RD_READY   = r_rd_ready;
    assign RD_DATA    = r_rd_data;
    assign RD_VALID   = r_rd_valid;
    assign MEM_ADDR   = r_mem_addr;
    assign MEM_OE     = r_mem_oe;
    assign BUSY       = r_busy;
    assign READ_DONE  = r_read_done;
    assign WORDS_LEFT = r_words_left;

endmodule
`default_nettype wire

// File: tb/tb_win_readout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_win_readout_ctrl
//  Description : Self-checking bench for win_readout_ctrl (ADDR_W=4, MEM_LAT=2,
//                memory returns data = address).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_win_readout_ctrl;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int MEM_LAT = 2;

    logic              clk;
    logic              rst_n;
    logic              write_ready;
    logic [ADDR_W-1:0] stop_addr;
    logic [ADDR_W-1:0] read_len;
    logic              start_read;
    logic              abort;
    logic              rd_req;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_oe;
    logic [DATA_W-1:0] mem_data;
    logic              busy;
    logic              read_done;
    logic [ADDR_W-1:0] words_left;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q[$];

    win_readout_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .WRITE_READY(write_ready),
        .STOP_ADDR  (stop_addr),
        .READ_LEN   (read_len),
        .START_READ (start_read),
        .ABORT      (abort),
        .RD_REQ     (rd_req),
        .RD_READY   (rd_ready),
        .RD_DATA    (rd_data),
        .RD_VALID   (rd_valid),
        .MEM_ADDR   (mem_addr),
        .MEM_OE     (mem_oe),
        .MEM_DATA   (mem_data),
        .BUSY       (busy),
        .READ_DONE  (read_done),
        .WORDS_LEFT (words_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data = address, valid MEM_LAT cycles after the read is issued.
    logic [DATA_W-1:0] r_mem_q;
    always @(posedge clk) r_mem_q <= mem_oe ? {4'b0000, mem_addr} : 8'hEE;
    assign mem_data = r_mem_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: every RD_VALID pops one expected word.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] l);
        write_ready = 1'b1;
        stop_addr   = s;
        read_len    = l;
        start_read  = 1'b1;
        tick();
        start_read  = 1'b0;
        stop_addr   = ~s;       // later changes must not matter
        read_len    = l + 4'd3;
    endtask

    task automatic req_word();
        int i;
        for (i = 0; i < 20 && !rd_ready; i++) tick();
        if (!rd_ready) chk("rd_ready_timeout", 32'(rd_ready), 32'd1);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        for (i = 0; i < 20 && !rd_valid; i++) tick();
        if (!rd_valid) chk("rd_valid_timeout", 32'(rd_valid), 32'd1);
        tick();
    endtask

    typedef struct {
        logic [ADDR_W-1:0] stop;
        logic [ADDR_W-1:0] len;
        logic [DATA_W-1:0] first;
        int                count;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{stop: 4'd9,  len: 4'd4,  first: 8'd6,  count: 4};
        vecs[1] = '{stop: 4'd1,  len: 4'd4,  first: 8'd14, count: 4};
        vecs[2] = '{stop: 4'd1,  len: 4'd0,  first: 8'd2,  count: 16};
        vecs[3] = '{stop: 4'd3,  len: 4'd2,  first: 8'd2,  count: 2};
        vecs[4] = '{stop: 4'd0,  len: 4'd1,  first: 8'd0,  count: 1};
        vecs[5] = '{stop: 4'd15, len: 4'd15, first: 8'd1,  count: 15};

        rst_n = 1'b0; write_ready = 1'b0; stop_addr = '0; read_len = '0;
        start_read = 1'b0; abort = 1'b0; rd_req = 1'b0;
        repeat (3) tick();
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_rd_ready",  32'(rd_ready),  32'd0);
        chk("rst_mem_oe",    32'(mem_oe),    32'd0);
        chk("rst_read_done", 32'(read_done), 32'd0);
        chk("rst_rd_data",   32'(rd_data),   32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven readouts; later vectors restart straight from DONE.
        foreach (vecs[v]) begin
            start(vecs[v].stop, vecs[v].len);
            chk("start_busy",       32'(busy),       32'd1);
            chk("start_words_left", 32'(words_left), 32'(vecs[v].len));
            for (int i = 0; i < vecs[v].count; i++) begin
                exp_q.push_back((vecs[v].first + 8'(i)) & 8'h0F);
                req_word();
            end
            tick();
            chk("done_read_done",  32'(read_done),    32'd1);
            chk("done_busy",       32'(busy),         32'd0);
            chk("done_words_left", 32'(words_left),   32'd0);
            chk("done_queue",      32'(exp_q.size()), 32'd0);
        end

        // DONE returns to IDLE when WRITE_READY falls.
        write_ready = 1'b0;
        tick();
        chk("done_to_idle_read_done", 32'(read_done), 32'd0);

        // START_READ without WRITE_READY is ignored.
        stop_addr = 4'd9; read_len = 4'd4; start_read = 1'b1;
        tick(); tick();
        start_read = 1'b0;
        chk("nowr_busy",     32'(busy),     32'd0);
        chk("nowr_rd_ready", 32'(rd_ready), 32'd0);

        // Exact timing: OE high two cycles, valid on the third; RD_REQ held through WAIT.
        start(4'd9, 4'd4);
        rd_req = 1'b1;
        exp_q.push_back(8'd6);
        tick();
        chk("t_k1_mem_oe",   32'(mem_oe),   32'd1);
        chk("t_k1_mem_addr", 32'(mem_addr), 32'd6);
        chk("t_k1_rd_ready", 32'(rd_ready), 32'd0);
        tick();
        chk("t_k2_mem_oe",   32'(mem_oe),   32'd1);
        chk("t_k2_rd_valid", 32'(rd_valid), 32'd0);
        tick();
        chk("t_k3_mem_oe",   32'(mem_oe),   32'd0);
        chk("t_k3_rd_valid", 32'(rd_valid), 32'd1);
        chk("t_k3_rd_ready", 32'(rd_ready), 32'd0);
        rd_req = 1'b0;
        tick();
        chk("t_k4_rd_valid",   32'(rd_valid),   32'd0);
        chk("t_k4_rd_ready",   32'(rd_ready),   32'd1);
        chk("t_k4_mem_oe",     32'(mem_oe),     32'd0);
        chk("t_k4_words_left", 32'(words_left), 32'd3);

        // WRITE_READY falls during WAIT: abort, no RD_VALID (scoreboard flags any).
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        write_ready = 1'b0;
        tick();
        chk("wrfall_busy",   32'(busy),     32'd0);
        chk("wrfall_mem_oe", 32'(mem_oe),   32'd0);
        repeat (4) tick();
        chk("wrfall_no_valid", 32'(rd_valid), 32'd0);

        // ABORT together with RD_REQ in READY: IDLE, MEM_OE never asserts.
        start(4'd9, 4'd4);
        abort = 1'b1; rd_req = 1'b1;
        tick();
        abort = 1'b0; rd_req = 1'b0;
        chk("abort_busy",     32'(busy),     32'd0);
        chk("abort_rd_ready", 32'(rd_ready), 32'd0);
        chk("abort_mem_oe",   32'(mem_oe),   32'd0);
        tick();
        chk("abort_mem_oe2",  32'(mem_oe),   32'd0);
        start(4'd9, 4'd4);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'd6 + 8'(i));
            req_word();
        end
        tick();
        chk("restart_read_done", 32'(read_done), 32'd1);

        // Asynchronous reset mid-WAIT clears outputs before the next edge.
        start(4'd9, 4'd4);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",     32'(busy),     32'd0);
        chk("arst_mem_oe",   32'(mem_oe),   32'd0);
        chk("arst_rd_ready", 32'(rd_ready), 32'd0);
        chk("arst_mem_addr", 32'(mem_addr), 32'd0);
        #2 rst_n = 1'b1;
        tick(); tick();
        chk("arst_idle_busy",  32'(busy),     32'd0);
        chk("arst_idle_valid", 32'(rd_valid), 32'd0);
        chk("end_queue",       32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
